// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// vga_fb_wr_if / vga_fb_mem_if : pixel-writer handshake and frame-buffer bus
// Rev 1.0
// ============================================================================

interface vga_fb_wr_if;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

interface vga_fb_mem_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter : single-port frame-buffer arbiter with scanout prefetch FIFO
// Rev 1.0
// ============================================================================

module vga_fb_arbiter #(
  parameter int WORDS      = 38400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pixel,
  input  logic [18:0]  p_count,
  input  logic         v_sync,
  vga_fb_wr_if.slave   wr,
  input  logic         clr_req,
  output logic         clr_busy,
  vga_fb_mem_if.master mem,
  output logic         pix_out,
  output logic         underrun
);

  localparam int PW = 17;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] C_WORDS    = PW'(WORDS);
  localparam logic [PW-1:0] C_LAST     = PW'(WORDS - 1);
  localparam logic [CW:0]   C_DEPTH    = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] C_IDX_LAST = AW'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_fetch_ptr;
  logic [PW-1:0]   r_clr_ptr;
  logic            r_rd_issue;
  logic            r_rd_valid;
  logic            r_vsync_d;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_idx;
  logic [AW-1:0]   r_wr_idx;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_mem_addr;
  logic            r_mem_we;
  logic [7:0]      r_mem_wdata;
  logic            r_wr_ack;
  logic            r_clr_busy;
  logic            r_pix;
  logic            r_underrun;

  logic            w_vs_fall;
  logic [CW:0]     w_level;
  logic            w_rd_go;
  logic            w_wr_go;
  logic            w_wr_in;
  logic            w_clr_go;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_head;
  logic            w_unused_pcount;

  assign w_unused_pcount = ^p_count[18:3];

  assign w_vs_fall = r_vsync_d & ~v_sync;
  // Reads already issued but not yet pushed still reserve a FIFO slot.
  assign w_level   = {1'b0, r_count} + (CW+1)'(r_rd_issue) + (CW+1)'(r_rd_valid);
  assign w_rd_go   = ~w_vs_fall && (w_level < C_DEPTH) && (r_fetch_ptr < C_WORDS);
  // The ack cycle is skipped so a requester still dropping WR_REQ is not served twice.
  assign w_wr_go   = wr.wr_req & ~r_wr_ack & ~w_rd_go;
  assign w_wr_in   = ({1'b0, wr.wr_addr} < C_WORDS);
  assign w_clr_go  = (r_state == S_CLEAR) & ~w_rd_go & ~w_wr_go;
  assign w_empty   = (r_count == '0);
  assign w_push    = r_rd_valid;
  assign w_pop     = pixel & (p_count[2:0] == 3'd7) & ~w_empty;
  assign w_head    = r_fifo[r_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d   <= 1'b1;
      r_fetch_ptr <= '0;
      r_rd_issue  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
      r_count     <= '0;
    end else begin
      r_vsync_d <= v_sync;
      if (w_vs_fall) begin
        r_fetch_ptr <= '0;
        r_rd_issue  <= 1'b0;
        r_rd_valid  <= 1'b0;
        r_rd_idx    <= '0;
        r_wr_idx    <= '0;
        r_count     <= '0;
      end else begin
        r_rd_issue <= w_rd_go;
        r_rd_valid <= r_rd_issue;
        if (w_rd_go)
          r_fetch_ptr <= r_fetch_ptr + PW'(1);
        if (w_push)
          r_wr_idx <= (r_wr_idx == C_IDX_LAST) ? '0 : r_wr_idx + AW'(1);
        if (w_pop)
          r_rd_idx <= (r_rd_idx == C_IDX_LAST) ? '0 : r_rd_idx + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_vs_fall)
      r_fifo[r_wr_idx] <= mem.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix      <= 1'b0;
      r_underrun <= 1'b0;
    end else if (pixel) begin
      if (w_empty) begin
        r_pix      <= 1'b0;
        r_underrun <= 1'b1;
      end else begin
        r_pix <= w_head[~p_count[2:0]];
      end
    end else begin
      r_pix <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_clr_ptr   <= '0;
      r_clr_busy  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_wr_ack <= w_wr_go;

      if (w_rd_go) begin
        r_mem_addr <= r_fetch_ptr[15:0];
      end else if (w_wr_go) begin
        if (w_wr_in) begin
          r_mem_addr  <= wr.wr_addr;
          r_mem_wdata <= wr.wr_data;
          r_mem_we    <= 1'b1;
        end
      end else if (w_clr_go) begin
        r_mem_addr  <= r_clr_ptr[15:0];
        r_mem_wdata <= 8'h00;
        r_mem_we    <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_clr_ptr  <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_clr_go) begin
            if (r_clr_ptr == C_LAST) begin
              r_state    <= S_IDLE;
              r_clr_busy <= 1'b0;
            end else begin
              r_clr_ptr <= r_clr_ptr + PW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_wdata = r_mem_wdata;
  assign wr.wr_ack     = r_wr_ack;
  assign clr_busy      = r_clr_busy;
  assign pix_out       = r_pix;
  assign underrun      = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_arbiter : randomized bench for vga_fb_arbiter against a frame model
// Rev 1.0
// ============================================================================

module tb_vga_fb_arbiter;

  localparam int WORDS      = 38400;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel;
  logic [18:0] p_count;
  logic        v_sync;
  logic        clr_req;
  logic        clr_busy;
  logic        pix_out;
  logic        underrun;

  vga_fb_wr_if  wr_bus ();
  vga_fb_mem_if mem_bus ();

  vga_fb_arbiter #(.WORDS(WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pixel    (pixel),
    .p_count  (p_count),
    .v_sync   (v_sync),
    .wr       (wr_bus),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .mem      (mem_bus),
    .pix_out  (pix_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame-buffer RAM, preloaded with word n = n[7:0].
  logic [7:0] mem_model [0:65535];
  logic [7:0] ref_fb    [0:65535];
  logic       mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int n = 0; n < 65536; n++) mem_model[n] <= n[7:0];
      mem_ready <= 1'b1;
    end else if (mem_bus.mem_we) begin
      mem_model[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    end
    mem_bus.mem_rdata <= mem_model[mem_bus.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int nerr;
  int busy_cnt, wr_cnt, bad;
  bit done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int waited;
    waited = 0;
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = a;
    wr_bus.wr_data = d;
    do begin
      tick();
      waited++;
    end while (wr_bus.wr_ack !== 1'b1 && waited < 64);
    chk("wr_ack", 32'(wr_bus.wr_ack), 32'd1);
    if (wr_bus.wr_ack === 1'b1) begin
      chk("wr_we", 32'(mem_bus.mem_we), 32'(int'(a) < WORDS));
      if (int'(a) < WORDS) begin
        chk("wr_addr", 32'(mem_bus.mem_addr), 32'(a));
        chk("wr_data", 32'(mem_bus.mem_wdata), 32'(d));
        ref_fb[a] = d;
      end
    end
    wr_bus.wr_req = 1'b0;
  endtask

  task automatic rand_writes(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(WORDS, 65535));
      else                           a = 16'($urandom_range(lo, hi));
      do_write(a, 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // Pixel p of a frame is bit (7 - p%8) of word p/8, shown one cycle later.
  task automatic run_frame(input int nwords, input bit gaps, input bit detail, output int errs);
    logic [7:0] w;
    logic       e;
    errs = 0;
    v_sync = 1'b0;
    tick();
    tick();
    v_sync = 1'b1;
    repeat (8) tick();
    for (int p = 0; p < nwords * 8; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pixel = 1'b0;
        tick();
        if (pix_out !== 1'b0) errs++;
      end
      pixel   = 1'b1;
      p_count = 19'(p);
      tick();
      w = ref_fb[p / 8];
      e = w[7 - (p % 8)];
      if (detail) chk($sformatf("pix%0d", p), 32'(pix_out), 32'(e));
      else if (pix_out !== e) errs++;
    end
    pixel = 1'b0;
  endtask

  task automatic fb_compare(input string tag);
    int mism;
    mism = 0;
    for (int a = 0; a < 65536; a++)
      if (mem_model[a] !== ref_fb[a]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    v_sync         = 1'b1;
    pixel          = 1'b0;
    p_count        = '0;
    clr_req        = 1'b0;
    wr_bus.wr_req  = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    for (int n = 0; n < 65536; n++) ref_fb[n] = n[7:0];
    repeat (3) tick();

    chk("rst_wr_ack",    32'(wr_bus.wr_ack),     32'd0);
    chk("rst_clr_busy",  32'(clr_busy),          32'd0);
    chk("rst_mem_we",    32'(mem_bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    chk("rst_pix_out",   32'(pix_out),           32'd0);
    chk("rst_underrun",  32'(underrun),          32'd0);

    // Write pending at reset release must wait for the four-word prefetch burst.
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 16'h0010;
    wr_bus.wr_data = 8'hA5;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 4) begin
        chk($sformatf("boot_rd_addr%0d", c), 32'(mem_bus.mem_addr), 32'(c - 1));
        chk($sformatf("boot_rd_we%0d", c),   32'(mem_bus.mem_we),   32'd0);
        chk($sformatf("boot_ack%0d", c),     32'(wr_bus.wr_ack),    32'd0);
      end else if (c == 5) begin
        chk("boot_wr_ack",   32'(wr_bus.wr_ack),     32'd1);
        chk("boot_wr_we",    32'(mem_bus.mem_we),    32'd1);
        chk("boot_wr_addr",  32'(mem_bus.mem_addr),  32'h0010);
        chk("boot_wr_data",  32'(mem_bus.mem_wdata), 32'hA5);
        wr_bus.wr_req = 1'b0;
        ref_fb[16'h0010] = 8'hA5;
      end else begin
        chk($sformatf("full_we%0d", c),   32'(mem_bus.mem_we),   32'd0);
        chk($sformatf("full_addr%0d", c), 32'(mem_bus.mem_addr), 32'h0010);
      end
    end

    do_write(16'(WORDS), 8'h3C);

    run_frame(2, 1'b0, 1'b1, nerr);
    chk("frame0_underrun", 32'(underrun), 32'd0);

    rand_writes(40, 0, 63);
    repeat (2) begin
      fork
        run_frame(64, 1'b1, 1'b0, nerr);
        rand_writes(30, 1000, WORDS - 1);
      join
      chk("frame_pix_errs", 32'(nerr), 32'd0);
      chk("frame_underrun", 32'(underrun), 32'd0);
    end
    repeat (2) tick();
    fb_compare("fb_after_writes");

    repeat (10) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_busy_start", 32'(clr_busy), 32'd1);
    busy_cnt = 1;
    wr_cnt   = 0;
    bad      = 0;
    done     = 1'b0;
    for (int i = 0; i < WORDS + 200 && !done; i++) begin
      clr_req = (i == 1000);
      tick();
      if (mem_bus.mem_we) begin
        if (mem_bus.mem_addr !== 16'(wr_cnt) || mem_bus.mem_wdata !== 8'h00) bad++;
        wr_cnt++;
      end
      if (clr_busy) busy_cnt++;
      if (!clr_busy && !mem_bus.mem_we) done = 1'b1;
    end
    clr_req = 1'b0;
    chk("clr_done",        32'(done),     32'd1);
    chk("clr_writes",      32'(wr_cnt),   32'(WORDS));
    chk("clr_busy_cycles", 32'(busy_cnt), 32'(WORDS));
    chk("clr_addr_seq",    32'(bad),      32'd0);
    repeat (5) tick();
    chk("clr_idle_after", 32'(clr_busy), 32'd0);
    for (int a = 0; a < WORDS; a++) ref_fb[a] = 8'h00;
    fb_compare("fb_after_clear");

    // Pixel requested right after a flush finds the FIFO empty.
    v_sync = 1'b0;
    tick();
    pixel   = 1'b1;
    p_count = '0;
    tick();
    chk("urun_pix",  32'(pix_out),  32'd0);
    chk("urun_flag", 32'(underrun), 32'd1);
    pixel  = 1'b0;
    v_sync = 1'b1;
    repeat (20) tick();
    chk("urun_sticky", 32'(underrun), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("urun_reset_clear", 32'(underrun), 32'd0);
    chk("reset_async_we",   32'(mem_bus.mem_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter WORDS, default 38400: frame-buffer depth in 8-pixel words (640x480/8).
REQ-002 Parameter FIFO_DEPTH, default 4: scanout prefetch FIFO depth in words.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RST_N  in  1  reset; asynchronous, active-low.
REQ-005 PIXEL  in  1  active-video flag from the VGA timing generator.
REQ-006 P_COUNT  in  19  active pixel index 0..307199 from the timing generator.
REQ-007 V_SYNC  in  1  vertical sync; active-low.
REQ-008 WR_REQ  in  1  write request; held high until WR_ACK.
REQ-009 WR_ADDR  in  16  word address; stable while WR_REQ high.
REQ-010 WR_DATA  in  8  pixel word, MSB = leftmost pixel; stable while WR_REQ high.
REQ-011 WR_ACK  out  1  one-cycle pulse; write slot granted.
REQ-012 CLR_REQ  in  1  one-cycle pulse; start full-screen clear.
REQ-013 CLR_BUSY  out  1  high while a clear is in progress.
REQ-014 MEM_ADDR  out  16  single-port frame-buffer address.
REQ-015 MEM_WE  out  1  frame-buffer write enable.
REQ-016 MEM_WDATA  out  8  frame-buffer write data.
REQ-017 MEM_RDATA  in  8  read data; valid the cycle after a read address (MEM_WE=0).
REQ-018 PIX_OUT  out  1  registered pixel to the DAC.
REQ-019 UNDERRUN  out  1  sticky scanout-underrun flag.

Function
REQ-020 One memory access per cycle; priority: prefetch read > WR write > clear write.
REQ-021 Prefetch read issued when (FIFO count + in-flight reads) < FIFO_DEPTH and fetch pointer < WORDS; MEM_ADDR = fetch pointer, MEM_WE=0; pointer increments.
REQ-022 Read data pushed into the FIFO the cycle after issue.
REQ-023 Falling edge of V_SYNC (1 then 0 on consecutive samples): FIFO flushed, in-flight read discarded, fetch pointer = 0.
REQ-024 PIXEL=1: PIX_OUT next cycle = bit (7 - P_COUNT[2:0]) of FIFO head; PIXEL=0: PIX_OUT next cycle = 0.
REQ-025 Head popped when PIXEL=1, P_COUNT[2:0]=7, FIFO non-empty.
REQ-026 PIXEL=1 with FIFO empty: PIX_OUT next cycle = 0, UNDERRUN set, no pop; UNDERRUN cleared only by reset.
REQ-027 WR_REQ=1 and no prefetch this cycle: MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA, MEM_WE=1, WR_ACK=1 same cycle.
REQ-028 WR_ADDR >= WORDS: WR_ACK=1 with MEM_WE=0 (write dropped).
REQ-029 FSM IDLE/CLEAR; IDLE + CLR_REQ -> CLEAR, clear pointer = 0, CLR_BUSY=1 from next cycle.
REQ-030 CLEAR: on cycles with no prefetch and no WR grant, write 0x00 at clear pointer, increment; after word WORDS-1 written -> IDLE, CLR_BUSY=0 next cycle.
REQ-031 CLR_REQ in CLEAR ignored; WR writes during CLEAR allowed (later clear may overwrite).
REQ-032 No access granted: MEM_WE=0, MEM_ADDR holds last value.

Reset
REQ-033 RST_N=0: FIFO empty, fetch pointer 0, no in-flight read, FSM IDLE, WR_ACK=0, CLR_BUSY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, PIX_OUT=0, UNDERRUN=0; mid-operation reset aborts clear/write immediately.

Verification
REQ-034 Reset release, V_SYNC high, model memory word n = n[7:0] -> reads at addresses 0,1,2,3 on first 4 cycles, then no read while FIFO full.
REQ-035 V_SYNC falling, then PIXEL=1, P_COUNT 0..15 -> PIX_OUT = bits of 0x00 then 0x01 (MSB first), each 1 cycle late; UNDERRUN=0.
REQ-036 WR_REQ held, addr 0x0010, data 0xA5, FIFO not full -> WR_ACK delayed until no prefetch; then MEM_WE=1, MEM_ADDR=0x0010, MEM_WDATA=0xA5 same cycle.
REQ-037 WR_ADDR=38400 -> WR_ACK pulse, MEM_WE=0.
REQ-038 CLR_REQ pulse, no video traffic -> CLR_BUSY high 38400 write cycles, all words 0x00, second CLR_REQ mid-clear ignored.
REQ-039 Model memory never returns data (FIFO held empty), PIXEL=1 -> PIX_OUT=0, UNDERRUN=1, stays 1 until RST_N=0.
